// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_mult_pkg : shared FSM state codes and width limit for seq_array_mult     |
// | Revision     : 1.0                                                           |
// +-----------------------------------------------------------------------------+
package seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int MAX_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/mult_cond_negate.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mult_cond_negate : combinational two's-complement negate when neg is high    |
// | Revision         : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module mult_cond_negate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  output logic [WIDTH-1:0] out_val
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign out_val = neg ? (~in_val + C_ONE) : in_val;

endmodule
`default_nettype wire

// File: rtl/seq_array_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_array_mult : iterative shift-add multiplier, one multiplier bit/cycle.   |
// | Optional early termination with `define SEQ_MULT_EARLY_TERM_EN.              |
// | Revision       : 1.0                                                         |
// +-----------------------------------------------------------------------------+
module seq_array_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("seq_array_mult: WIDTH must be in 2..16");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      p_q, p_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      acc_shift;
  logic [PW-1:0]      prod_fix;

  // Signed operands enter the datapath as magnitudes; -2^(WIDTH-1) maps onto itself.
  mult_cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .in_val  (in_a),
    .neg     (in_signed & in_a[WIDTH-1]),
    .out_val (mag_a)
  );

  mult_cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .in_val  (in_b),
    .neg     (in_signed & in_b[WIDTH-1]),
    .out_val (mag_b)
  );

  mult_cond_negate #(.WIDTH(PW)) u_neg_p (
    .in_val  (acc_q),
    .neg     (neg_q),
    .out_val (prod_fix)
  );

  assign sum       = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign acc_shift = {sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          acc_d    = '0;
          neg_d    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          cnt_d    = C_CNT_INIT;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Counter at zero: all bits consumed, register the sign-corrected product.
        if (cnt_q == '0) begin
          p_d     = prod_fix;
          state_d = DONE;
        end else begin
          mplier_d = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (mplier_q[WIDTH-1:1] == '0) begin
            acc_d = acc_shift >> (cnt_q - C_CNT_ONE);
            cnt_d = '0;
          end else begin
            acc_d = acc_shift;
            cnt_d = cnt_q - C_CNT_ONE;
          end
`else
          acc_d = acc_shift;
          cnt_d = cnt_q - C_CNT_ONE;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = p_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seq_array_mult : WIDTH=4 and WIDTH=16 instances against a reference model |
// | Revision          : 1.0                                                      |
// +-----------------------------------------------------------------------------+
module tb_seq_array_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic        sg   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic        bz   [2];
  logic [15:0] a    [2];
  logic [15:0] b    [2];
  logic [7:0]  p4;
  logic [31:0] p16;
  logic [31:0] pv   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_busy  [2];
  logic        m_valid [2];
  int          m_left  [2];
  logic [31:0] m_prod  [2];
  logic [31:0] m_p     [2];

  always #5 clk = ~clk;

  seq_array_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(a[0][3:0]), .in_b(b[0][3:0]), .in_signed(sg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(p4), .busy(bz[0])
  );

  seq_array_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(a[1]), .in_b(b[1]), .in_signed(sg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(p16), .busy(bz[1])
  );

  always_comb begin
    pv[0] = {24'd0, p4};
    pv[1] = p16;
  end

  function automatic int wid(int k);
    return (k == 0) ? 4 : 16;
  endfunction

  function automatic logic [31:0] exp_prod(int w, logic [15:0] a_i, logic [15:0] b_i, bit s);
    longint mk, sa, sb;
    logic [63:0] r;
    mk = (longint'(1) << w) - 1;
    sa = longint'(a_i) & mk;
    sb = longint'(b_i) & mk;
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    r = sa * sb;
    r = r & ((64'd1 << (2 * w)) - 64'd1);
    return r[31:0];
  endfunction

  // Number of RUN cycles the multiplier magnitude costs.
  function automatic int run_cycles(int w, logic [15:0] b_i, bit s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint bm;
    int hi;
    bm = longint'(b_i) & ((longint'(1) << w) - 1);
    if (s && bm[w-1]) bm = (longint'(1) << w) - bm;
    if (bm == 0) return 1;
    hi = 0;
    for (int i = 0; i < w; i++) if (bm[i]) hi = i;
    return hi + 1;
`else
    if (s || b_i[0] || !b_i[0]) return w;
    return w;
`endif
  endfunction

  task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: acceptance, fixed latency, then hold until consumed.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k]  <= 1'b0;
        m_valid[k] <= 1'b0;
        m_left[k]  <= 0;
        m_prod[k]  <= '0;
        m_p[k]     <= '0;
      end else if (!m_busy[k]) begin
        if (iv[k]) begin
          m_busy[k] <= 1'b1;
          m_left[k] <= run_cycles(wid(k), b[k], sg[k]) + 1;
          m_prod[k] <= exp_prod(wid(k), a[k], b[k], sg[k]);
        end
      end else if (!m_valid[k]) begin
        if (m_left[k] == 1) begin
          m_valid[k] <= 1'b1;
          m_p[k]     <= m_prod[k];
        end
        m_left[k] <= m_left[k] - 1;
      end else if (ordy[k]) begin
        m_busy[k]  <= 1'b0;
        m_valid[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check("in_ready", k, {31'd0, ir[k]}, {31'd0, !m_busy[k]});
        check("busy", k, {31'd0, bz[k]}, {31'd0, m_busy[k]});
        check("out_valid", k, {31'd0, ov[k]}, {31'd0, m_valid[k]});
        if (m_valid[k]) check("out_p", k, pv[k], m_p[k]);
      end
    end
  end

  task automatic send(int k, logic [15:0] a_i, logic [15:0] b_i, bit s_i);
    int guard;
    guard = 0;
    while (!ir[k] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", k, 32'd0, 32'd1);
    iv[k] = 1'b1; a[k] = a_i; b[k] = b_i; sg[k] = s_i;
    @(posedge clk); #1;
    iv[k] = 1'b0; a[k] = 16'($urandom); b[k] = 16'($urandom); sg[k] = 1'($urandom);
    if (k == 0) begin
      a[k][15:4] = '0;
      b[k][15:4] = '0;
    end
  endtask

  task automatic wait_valid(int k, output int lat, output logic [31:0] got);
    lat = 0;
    while (!ov[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 64) check("out_valid_timeout", k, 32'd0, 32'd1);
    got = pv[k];
  endtask

  task automatic consume(int k, bit rand_rdy);
    if (rand_rdy) begin
      ordy[k] = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_op(int k, logic [15:0] a_i, logic [15:0] b_i, bit s_i, bit rand_rdy,
                        output logic [31:0] got);
    int lat;
    send(k, a_i, b_i, s_i);
    wait_valid(k, lat, got);
    consume(k, rand_rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int lat;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; sg[k] = 0; ordy[k] = 1; a[k] = '0; b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 0, {31'd0, ir[0]}, 32'd1);
    check("reset_out_valid", 0, {31'd0, ov[0]}, 32'd0);
    check("reset_out_p", 0, pv[0], 32'd0);
    check("reset_busy", 0, {31'd0, bz[0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 15*15 unsigned, latency pinned to 5 edges
    send(0, 16'd15, 16'd15, 1'b0);
    lat = 0;
    while (!ov[0] && lat < 64) begin
      check("busy_in_ready", 0, {31'd0, ir[0]}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("lat_15x15", 0, lat, 32'd5);
    check("p_15x15", 0, pv[0], 32'h00E1);
    consume(0, 1'b0);

    run_op(0, 16'h8, 16'h8, 1'b1, 1'b0, got);
    check("p_m8xm8", 0, got, 32'h40);
    run_op(0, 16'h8, 16'h7, 1'b1, 1'b0, got);
    check("p_m8x7", 0, got, 32'hC8);
    run_op(0, 16'h8, 16'h7, 1'b0, 1'b0, got);
    check("p_8x7u", 0, got, 32'h38);
    run_op(0, 16'h0, 16'hA, 1'b1, 1'b0, got);
    check("p_0xm6", 0, got, 32'h0);

    // backpressure: result must hold and new offers must be ignored
    ordy[0] = 1'b0;
    send(0, 16'd3, 16'd5, 1'b0);
    wait_valid(0, lat, got);
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1; a[0] = 16'(i + 1); b[0] = 16'd9;
      @(posedge clk); #1;
      check("bp_p", 0, pv[0], 32'h0F);
      check("bp_valid", 0, {31'd0, ov[0]}, 32'd1);
      check("bp_ready", 0, {31'd0, ir[0]}, 32'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 0, {31'd0, ir[0]}, 32'd1);
    check("bp_release_valid", 0, {31'd0, ov[0]}, 32'd0);

    // asynchronous reset in the middle of RUN
    send(0, 16'd9, 16'd9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 0, {31'd0, ir[0]}, 32'd1);
    check("arst_valid", 0, {31'd0, ov[0]}, 32'd0);
    check("arst_p", 0, pv[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 16'd2, 16'd3, 1'b0, 1'b0, got);
    check("p_2x3", 0, got, 32'd6);

    for (int i = 0; i < 300; i++) begin
      run_op(0, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), 1'($urandom), 1'b1, got);
    end

    // WIDTH=16 corners
    run_op(1, 16'h8000, 16'h8000, 1'b1, 1'b0, got);
    check("p16_min_sq", 1, got, 32'h4000_0000);
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, got);
    check("p16_max_u", 1, got, 32'hFFFE_0001);
    run_op(1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, got);
    check("p16_m1x1", 1, got, 32'hFFFF_FFFF);
    run_op(1, 16'h0000, 16'h8000, 1'b1, 1'b0, got);
    check("p16_0xmin", 1, got, 32'h0);
    run_op(1, 16'h00FF, 16'h0003, 1'b0, 1'b0, got);
    check("p16_ffx3", 1, got, 32'h02FD);

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      if (i % 8 == 1 || i % 8 == 2) iv[1] = 1'b0;
      run_op(1, ra, rb, 1'($urandom), 1'b1, got);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
